// File: rtl/sum_of_squares.sv
// Iterative shift-add computation of gx^2 + gy^2 for the magnitude path.
// Define SUM_OF_SQUARES_RADIX4_EN to retire two multiplier bits per cycle (halves latency).
module sum_of_squares #(
    parameter  int SIZE_IN  = 12,
    localparam int SIZE_OUT = 2 * SIZE_IN
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic signed [SIZE_IN-1:0]  i_gx,
    input  logic signed [SIZE_IN-1:0]  i_gy,
    input  logic                       i_valid,
    output logic                       o_busy,
    output logic [SIZE_OUT-1:0]        o_data,
    output logic                       o_data_ready
);

`ifdef SUM_OF_SQUARES_RADIX4_EN
    localparam int STEP = 2;
    generate
        if (SIZE_IN % 2 != 0) begin : g_odd_size_check
            $error("SIZE_IN must be even when SUM_OF_SQUARES_RADIX4_EN is defined");
        end
    endgenerate
`else
    localparam int STEP = 1;
`endif

    localparam int ITERS = SIZE_IN / STEP;
    localparam int CNT_W = $clog2(SIZE_IN) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, SQ_X, SQ_Y, DONE} state_t;

    state_t                state_q, state_d;
    logic [SIZE_IN-1:0]    gx_mag_q, gx_mag_d;
    logic [SIZE_IN-1:0]    gy_mag_q, gy_mag_d;
    logic [SIZE_OUT-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SIZE_OUT-1:0]   data_q, data_d;

    logic [SIZE_IN-1:0]    op_mag;
    logic [SIZE_IN-1:0]    mag_sh;
    logic [SIZE_OUT-1:0]   op_ext;
    logic [SIZE_OUT-1:0]   addend;
    logic [SIZE_OUT-1:0]   acc_sum;
    logic [CNT_W-1:0]      shamt;

    // The most negative input maps to 2^(SIZE_IN-1), which still fits unsigned.
    function automatic logic [SIZE_IN-1:0] abs_mag(input logic [SIZE_IN-1:0] v);
        return v[SIZE_IN-1] ? ((~v) + SIZE_IN'(1)) : v;
    endfunction

    always_comb begin
        op_mag = (state_q == SQ_Y) ? gy_mag_q : gx_mag_q;
`ifdef SUM_OF_SQUARES_RADIX4_EN
        shamt  = cnt_q << 1;
`else
        shamt  = cnt_q;
`endif
        mag_sh = op_mag >> shamt;
        op_ext = SIZE_OUT'(op_mag);
        addend = '0;
        if (mag_sh[0]) begin
            addend = op_ext << shamt;
        end
`ifdef SUM_OF_SQUARES_RADIX4_EN
        if (mag_sh[1]) begin
            addend = addend + (op_ext << (shamt + CNT_W'(1)));
        end
`endif
        acc_sum = acc_q + addend;
    end

    always_comb begin
        state_d  = state_q;
        gx_mag_d = gx_mag_q;
        gy_mag_d = gy_mag_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        case (state_q)
            IDLE, DONE: begin
                if (i_valid) begin
                    gx_mag_d = abs_mag(i_gx);
                    gy_mag_d = abs_mag(i_gy);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = SQ_X;
                end else begin
                    state_d  = IDLE;
                end
            end
            SQ_X: begin
                acc_d = acc_sum;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = SQ_Y;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            SQ_Y: begin
                acc_d = acc_sum;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    data_d  = acc_sum;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            gx_mag_q <= '0;
            gy_mag_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            gx_mag_q <= gx_mag_d;
            gy_mag_q <= gy_mag_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
        end
    end

    assign o_busy       = (state_q == SQ_X) || (state_q == SQ_Y);
    assign o_data_ready = (state_q == DONE);
    assign o_data       = data_q;

endmodule

// File: tb/tb_sum_of_squares.sv
// Bench for sum_of_squares: vector table, reset-abort sequence, and randomized pairs
// checked against plain integer arithmetic gx*gx + gy*gy.
module tb_sum_of_squares;
    localparam int SIZE_IN  = 12;
    localparam int SIZE_OUT = 2 * SIZE_IN;
`ifdef SUM_OF_SQUARES_RADIX4_EN
    localparam int LAT = SIZE_IN;
`else
    localparam int LAT = 2 * SIZE_IN;
`endif

    logic                      clk = 1'b0;
    logic                      i_reset;
    logic                      i_valid;
    logic signed [SIZE_IN-1:0] i_gx;
    logic signed [SIZE_IN-1:0] i_gy;
    logic                      o_busy;
    logic [SIZE_OUT-1:0]       o_data;
    logic                      o_data_ready;

    always #5 clk = ~clk;

    sum_of_squares #(.SIZE_IN(SIZE_IN)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_gx        (i_gx),
        .i_gy        (i_gy),
        .i_valid     (i_valid),
        .o_busy      (o_busy),
        .o_data      (o_data),
        .o_data_ready(o_data_ready)
    );

    typedef struct {
        int    gx;
        int    gy;
        int    expv;
        bit    hold;
        bit    chain;
        string name;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int pulses_seen = 0;
    int pulses_exp = 0;
    bit mon_en = 1'b0;
    logic [SIZE_OUT-1:0] prev_data = '0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // o_data may only move on the edge entering DONE, or when reset clears it.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            if (o_data_ready) pulses_seen++;
            if (o_data !== prev_data) begin
                checks++;
                if (!o_data_ready && !i_reset) begin
                    errors++;
                    $display("FAIL data_stable actual=%0d required=%0d", o_data, prev_data);
                end
            end
        end
        prev_data = o_data;
    end

    // Presents one pair at a negedge where the DUT is IDLE or DONE, then waits for the pulse.
    task automatic txn(input int gx, input int gy, input int expv, input bit hold, input string name);
        int n = 0;
        bit got = 1'b0;
        bit busy_ok = 1'b1;
        i_gx    = SIZE_IN'(gx);
        i_gy    = SIZE_IN'(gy);
        i_valid = 1'b1;
        @(negedge clk);
        while (!got && n <= LAT + 4) begin
            if (o_data_ready) begin
                got = 1'b1;
            end else begin
                if (!o_busy) busy_ok = 1'b0;
                i_gx    = SIZE_IN'($urandom);
                i_gy    = SIZE_IN'($urandom);
                i_valid = hold;
                @(negedge clk);
                n++;
            end
        end
        pulses_exp++;
        check({name, " latency"}, got ? n : -1, LAT);
        check({name, " data"}, o_data, expv);
        check({name, " busy"}, {30'd0, busy_ok, o_busy}, 2);
        $display("txn %s gx=%0d gy=%0d data=%0d expected=%0d latency=%0d", name, gx, gy, o_data, expv, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int gx, gy;
        vecs[0] = '{3, 4, 25, 1'b0, 1'b0, "p3_4"};
        vecs[1] = '{-2048, -2048, 8388608, 1'b0, 1'b0, "min_min"};
        vecs[2] = '{2047, 0, 4190209, 1'b0, 1'b0, "max_zero"};
        vecs[3] = '{0, 0, 0, 1'b0, 1'b0, "zero"};
        vecs[4] = '{-5, 12, 169, 1'b0, 1'b0, "mixed"};
        vecs[5] = '{1, 1, 2, 1'b1, 1'b1, "b2b_1"};
        vecs[6] = '{2, 2, 8, 1'b1, 1'b1, "b2b_2"};
        vecs[7] = '{7, -7, 98, 1'b1, 1'b0, "b2b_7"};

        i_reset = 1'b1;
        i_valid = 1'b0;
        i_gx    = '0;
        i_gy    = '0;
        repeat (3) @(negedge clk);
        check("reset o_data", o_data, 0);
        check("reset o_data_ready", o_data_ready, 0);
        check("reset o_busy", o_busy, 0);
        i_reset = 1'b0;
        prev_data = o_data;
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].gx, vecs[i].gy, vecs[i].expv, vecs[i].hold, vecs[i].name);
            if (!vecs[i].chain) begin
                i_valid = 1'b0;
                @(negedge clk);
            end
        end

        // Abort mid-SQ_Y with reset: no pulse, o_data cleared, then a clean run.
        i_gx    = 12'sd100;
        i_gy    = 12'sd200;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (LAT * 3 / 4) @(negedge clk);
        check("abort busy before reset", o_busy, 1);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check("abort o_busy", o_busy, 0);
        check("abort o_data", o_data, 0);
        check("abort o_data_ready", o_data_ready, 0);
        $display("txn abort gx=100 gy=200 data=%0d busy=%0d", o_data, o_busy);
        @(negedge clk);
        txn(6, 8, 100, 1'b0, "after_abort");
        i_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 1200; i++) begin
            bit hold, chain;
            case ($urandom_range(0, 9))
                0:       begin gx = -2048; gy = $urandom_range(0, 4095) - 2048; end
                1:       begin gx = $urandom_range(0, 4095) - 2048; gy = 2047; end
                default: begin gx = $urandom_range(0, 4095) - 2048; gy = $urandom_range(0, 4095) - 2048; end
            endcase
            hold  = 1'($urandom_range(0, 1));
            chain = 1'($urandom_range(0, 1));
            txn(gx, gy, gx * gx + gy * gy, hold, $sformatf("rnd%0d", i));
            if (!chain) begin
                i_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        i_valid = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("pulse count", pulses_seen, pulses_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
